// File: rtl/ram_1024x12_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_1024x12_pkg
// Description : Shared constants and reset-style enumeration for the
//               1024x12 simple dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_1024x12_pkg;

   localparam int c_ADDR_WIDTH = 10;
   localparam int c_DATA_WIDTH = 12;
   localparam int c_DEPTH      = 1024;

   // How a port reset is applied to that port's registers
   typedef enum logic [1:0] {
      RST_ASYNC           = 2'd0,
      RST_SYNC            = 2'd1,
      RST_SYNC_INTERNALLY = 2'd2
   } reset_type_e;

endpackage : ram_1024x12_pkg
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
// Module      : reset_sync
// Description : Two-flop reset synchronizer; asserts asynchronously and
//               releases synchronously to clk.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sync (
   input  logic clk,
   input  logic rst,
   output logic rst_sync
);

   logic [1:0] r_sync;

   // Shift zeros in after release so deassertion lands two clk edges later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], 1'b0};
      end
   end

   assign rst_sync = r_sync[1];

endmodule : reset_sync
`default_nettype wire

// File: rtl/ram_1024x12.sv
`default_nettype none
// ============================================================================
// Module      : ram_1024x12
// Description : Simple dual-port RAM (one write port, one read port) with
//               independent clocks, read-first behaviour, optional output
//               register and selectable read-port reset style.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_1024x12
   import ram_1024x12_pkg::*;
#(
   parameter int    ADDR_WIDTH = c_ADDR_WIDTH,
   parameter int    DATA_WIDTH = c_DATA_WIDTH,
   parameter int    OUTPUT_REG = 0,
   parameter string RESET_TYPE = "ASYNC"
) (
   input  logic                  wr_clk,
   input  logic                  wr_rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   localparam int c_depth = 2 ** ADDR_WIDTH;
   localparam reset_type_e c_rst_kind =
      (RESET_TYPE == "SYNC")            ? RST_SYNC :
      (RESET_TYPE == "SYNC_INTERNALLY") ? RST_SYNC_INTERNALLY :
                                          RST_ASYNC;

   // No reset on the array or its read register so the pair maps onto block RAM
   logic [DATA_WIDTH-1:0] r_mem [c_depth];
   logic [DATA_WIDTH-1:0] r_rd_mem;
   logic                  r_rd_clr;
   logic [DATA_WIDTH-1:0] w_stage1;
   logic                  w_wr_rst;
   logic                  w_rd_rst;

   // Pick the reset each domain actually sees
   generate
      if (c_rst_kind == RST_SYNC_INTERNALLY) begin : g_rst_internal
         reset_sync u_wr_rst_sync (
            .clk      (wr_clk),
            .rst      (wr_rst),
            .rst_sync (w_wr_rst)
         );
         reset_sync u_rd_rst_sync (
            .clk      (rd_clk),
            .rst      (rd_rst),
            .rst_sync (w_rd_rst)
         );
      end else begin : g_rst_direct
         assign w_wr_rst = wr_rst;
         assign w_rd_rst = rd_rst;
      end
   endgenerate

   // Write port: reset only blocks writes, never touches the contents
   always_ff @(posedge wr_clk) begin
      if (wr_en && !w_wr_rst) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Read port: unconditional read every edge; NBA ordering gives read-first
   always_ff @(posedge rd_clk) begin
      r_rd_mem <= r_mem[rd_addr];
   end

   // A clear flag masks the raw RAM output while reset is pending, so the
   // array read register itself stays reset-free
   assign w_stage1 = r_rd_clr ? '0 : r_rd_mem;

   generate
      if (c_rst_kind == RST_SYNC) begin : g_rd_sync
         // Clear flag follows rd_rst only at rd_clk edges
         always_ff @(posedge rd_clk) begin
            r_rd_clr <= w_rd_rst;
         end

         if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_rd_out;
            // Extra output stage cleared synchronously
            always_ff @(posedge rd_clk) begin
               if (w_rd_rst) begin
                  r_rd_out <= '0;
               end else begin
                  r_rd_out <= w_stage1;
               end
            end
            assign rd_data = r_rd_out;
         end else begin : g_no_oreg
            assign rd_data = w_stage1;
         end
      end else begin : g_rd_async
         // Clear flag sets the moment reset asserts
         always_ff @(posedge rd_clk or posedge w_rd_rst) begin
            if (w_rd_rst) begin
               r_rd_clr <= 1'b1;
            end else begin
               r_rd_clr <= 1'b0;
            end
         end

         if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] r_rd_out;
            // Extra output stage cleared asynchronously
            always_ff @(posedge rd_clk or posedge w_rd_rst) begin
               if (w_rd_rst) begin
                  r_rd_out <= '0;
               end else begin
                  r_rd_out <= w_stage1;
               end
            end
            assign rd_data = r_rd_out;
         end else begin : g_no_oreg
            assign rd_data = w_stage1;
         end
      end
   endgenerate

endmodule : ram_1024x12
`default_nettype wire

// File: tb/tb_ram_1024x12.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_1024x12
// Description : Scoreboard bench for ram_1024x12 (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_1024x12;

   logic        wr_clk    = 1'b0;
   logic        rd_clk    = 1'b0;
   logic        tb_wr_rst = 1'b1;
   logic        rd_rst    = 1'b1;
   logic        wr_en     = 1'b0;
   logic [9:0]  wr_addr   = '0;
   logic [11:0] wr_data   = '0;
   logic [9:0]  rd_addr   = '0;
   logic [11:0] rd_data;

   // Global reset net of the GTP_GRS primitive, GRS_N tied inactive high
   logic        grs_n     = 1'b1;
   logic        wr_rst;
   assign wr_rst = tb_wr_rst | ~grs_n;

   int          checks = 0;
   int          errors = 0;
   logic [11:0] exp_q [$];
   logic        rd_req = 1'b0;

   ram_1024x12 dut (
      .wr_clk  (wr_clk),
      .wr_rst  (wr_rst),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_clk  (rd_clk),
      .rd_rst  (rd_rst),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // Both clocks 10 ns, in phase so same-cycle read/write lines up
   always #5 wr_clk = ~wr_clk;
   always #5 rd_clk = ~rd_clk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic read_expect(input logic [9:0] addr, input logic [11:0] exp);
      rd_addr = addr;
      exp_q.push_back(exp);
      @(negedge wr_clk);
   endtask

   // Monitor: every tracked read edge presents one word, one cycle latency
   initial begin
      forever begin
         @(posedge rd_clk);
         if (rd_req) begin
            #1;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rd_data: got %h expected <none queued>", rd_data);
            end else begin
               check("rd_data", rd_data, exp_q.pop_front());
            end
         end
      end
   end

   // Stimulus
   initial begin
      // 200 ns of reset on both ports, output must sit at zero
      repeat (20) begin
         @(negedge wr_clk);
         check("reset_hold", rd_data, 12'h000);
      end
      tb_wr_rst = 1'b0;
      rd_rst    = 1'b0;

      // Address 0 gets a known value so the idle read during writes is defined
      wr_en   = 1'b1;
      wr_addr = 10'd0;
      wr_data = 12'h000;
      rd_addr = 10'd0;
      @(negedge wr_clk);

      // Sequential write 1..1023 while reading addr 0 (must stay undisturbed)
      rd_req = 1'b1;
      for (int k = 1; k < 1024; k++) begin
         wr_addr = 10'(k);
         wr_data = 12'(4096 - k);
         exp_q.push_back(12'h000);
         @(negedge wr_clk);
      end
      wr_en = 1'b0;

      // Sequential read 1..1023
      for (int k = 1; k < 1024; k++) begin
         read_expect(10'(k), 12'(4096 - k));
      end

      // Read-during-write on addr 5: old data, then new data
      wr_en   = 1'b1;
      wr_addr = 10'd5;
      wr_data = 12'hA5A;
      read_expect(10'd5, 12'hFFB);
      wr_en = 1'b0;
      read_expect(10'd5, 12'hA5A);

      // Write disabled: addr 10 keeps its content
      wr_addr = 10'd10;
      wr_data = 12'h123;
      read_expect(10'd10, 12'hFF6);
      read_expect(10'd10, 12'hFF6);

      // Write-port reset blocks a write but leaves reads running
      tb_wr_rst = 1'b1;
      wr_en     = 1'b1;
      wr_addr   = 10'd20;
      wr_data   = 12'h555;
      read_expect(10'd20, 12'hFEC);
      tb_wr_rst = 1'b0;
      wr_en     = 1'b0;
      read_expect(10'd20, 12'hFEC);

      // Read-port reset in the middle of a read of addr 3
      read_expect(10'd3, 12'hFFD);
      rd_req = 1'b0;
      #2;
      rd_rst = 1'b1;
      #1;
      check("rd_rst_async", rd_data, 12'h000);
      @(negedge wr_clk);
      check("rd_rst_hold", rd_data, 12'h000);
      rd_rst = 1'b0;
      rd_req = 1'b1;
      read_expect(10'd3, 12'hFFD);
      rd_req = 1'b0;

      // Drain the scoreboard with a bounded wait
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
         @(negedge rd_clk);
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ram_1024x12
`default_nettype wire
